// File: rtl/rv_mem_arb.sv
// Arbiter sharing one single-port synchronous RAM between the core fetch port, the core data port
// and a DMA/debug port. Conflicting core accesses are split over two cycles.
module rv_mem_arb #(
    parameter int unsigned MAXWAIT = 4,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_adr,
    input  logic          i_re,
    output logic [31:0]   i_dr,
    output logic          i_rdy,
    input  logic [AW-1:0] d_adr,
    input  logic          d_re,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_dw,
    output logic [31:0]   d_dr,
    output logic          d_rdy,
    input  logic          x_req,
    input  logic [AW-1:0] x_adr,
    input  logic [3:0]    x_we,
    input  logic [31:0]   x_dw,
    output logic          x_gnt,
    output logic [31:0]   x_dr,
    output logic          x_vld,
    output logic [AW-1:0] m_adr,
    output logic          m_re,
    output logic [3:0]    m_we,
    output logic [31:0]   m_dw,
    input  logic [31:0]   m_dr,
    input  logic          m_rdy
);

    typedef enum logic [1:0] {StCore, StSplit, StDma} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        dsel_q;
    logic [31:0] d_hold_q;
    logic        x_vld_q;
    logic        rdy;

    logic d_acc;
    logic x_force;

    assign d_acc   = (d_we != 4'b0000) || d_re;
    assign x_force = x_req && (wcnt_q == 4'(MAXWAIT));

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        x_gnt   = 1'b0;
        m_adr   = '0;
        m_re    = 1'b0;
        m_we    = 4'b0000;
        m_dw    = 32'h0;

        unique case (state_q)
            StCore: begin
                if (x_force) begin
                    m_adr   = x_adr;
                    m_re    = (x_we == 4'b0000);
                    m_we    = x_we;
                    m_dw    = x_dw;
                    x_gnt   = 1'b1;
                    state_d = StDma;
                end else if (d_acc) begin
                    m_adr = d_adr;
                    m_re  = (d_we == 4'b0000);
                    m_we  = d_we;
                    m_dw  = d_dw;
                    // Fetch is deferred to the next cycle when both core ports want the RAM.
                    if (i_re) begin
                        state_d = StSplit;
                    end else begin
                        rdy = 1'b1;
                    end
                end else if (i_re) begin
                    m_adr = i_adr;
                    m_re  = 1'b1;
                    rdy   = 1'b1;
                end else if (x_req) begin
                    m_adr = x_adr;
                    m_re  = (x_we == 4'b0000);
                    m_we  = x_we;
                    m_dw  = x_dw;
                    x_gnt = 1'b1;
                    rdy   = 1'b1;
                end else begin
                    rdy = 1'b1;
                end
            end
            StSplit: begin
                m_adr   = i_adr;
                m_re    = 1'b1;
                rdy     = 1'b1;
                state_d = StCore;
            end
            StDma: begin
                state_d = StCore;
            end
            default: begin
                state_d = StCore;
            end
        endcase

        if (!m_rdy) begin
            rdy   = 1'b0;
            x_gnt = 1'b0;
        end

        // Nothing reaches the RAM while reset is asserted.
        if (reset) begin
            rdy   = 1'b0;
            x_gnt = 1'b0;
            m_adr = '0;
            m_re  = 1'b0;
            m_we  = 4'b0000;
            m_dw  = 32'h0;
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (!x_req || x_gnt) begin
            wcnt_d = 4'd0;
        end else if (wcnt_q < 4'(MAXWAIT)) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StCore;
            wcnt_q   <= 4'd0;
            dsel_q   <= 1'b0;
            d_hold_q <= 32'h0;
            x_vld_q  <= 1'b0;
        end else if (m_rdy) begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            dsel_q  <= (state_q == StSplit);
            x_vld_q <= x_gnt && (x_we == 4'b0000);
            if (state_q == StSplit) begin
                d_hold_q <= m_dr;
            end
        end
    end

    assign i_rdy = rdy;
    assign d_rdy = rdy;
    assign i_dr  = m_dr;
    assign x_dr  = m_dr;
    assign d_dr  = dsel_q ? d_hold_q : m_dr;
    assign x_vld = x_vld_q;

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Shares one synchronous single-port RAM (1-cycle read latency) between three requesters: the rv_core instruction port, the rv_core data port and a DMA/debug port.
- Sequences conflicting accesses over several cycles. Stalls the core through a common ready (i_rdy = d_rdy). Bounds DMA starvation with a wait counter.
- Sits between rv_core and the on-chip RAM.

Parameters:
- MAXWAIT, 4: number of consecutive cycles x_req may wait with no grant before the DMA port is forced in (1..15).
- AW, 32: address width of all ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- i_adr  in  AW  instruction address
- i_re  in  1  instruction read request
- i_dr  out  32  instruction read data
- i_rdy  out  1  core ready (always equal to d_rdy)
- d_adr  in  AW  data address
- d_re  in  1  data read request
- d_we  in  4  data byte write enables
- d_dw  in  32  data write data
- d_dr  out  32  data read data
- d_rdy  out  1  core ready
- x_req  in  1  DMA request
- x_adr  in  AW  DMA address
- x_we  in  4  DMA byte write enables (0 = read)
- x_dw  in  32  DMA write data
- x_gnt  out  1  DMA access issued this cycle
- x_dr  out  32  DMA read data
- x_vld  out  1  x_dr valid
- m_adr  out  AW  RAM address
- m_re  out  1  RAM read enable
- m_we  out  4  RAM byte write enables
- m_dw  out  32  RAM write data
- m_dr  in  32  RAM read data (valid the cycle after issue)
- m_rdy  in  1  RAM ready; 0 = wait state, hold everything

Behaviour:
- Definitions:
  - Data access: d_we != 0 or d_re.
  - If d_we != 0 the access is a write; d_re is ignored.
  - A core access is accepted at the edge where i_rdy = 1 and m_rdy = 1.
  - Read data for an accepted access is driven on i_dr/d_dr throughout the following cycle.
- Reset (synchronous, active-high):
  - state = CORE, wcnt = 0, dsel = 0.
  - i_rdy = d_rdy = 0, x_gnt = x_vld = 0.
  - m_re = 0, m_we = 0, m_adr = 0, m_dw = 0.
  - d_hold = 0.
  - Reset asserted mid-split or mid-DMA abandons the access; no write is issued during reset.
- States: CORE, SPLIT, DMA.
- CORE:
  - DMA is forced if x_req and wcnt == MAXWAIT.
    - Issue x_* on m_*, x_gnt = 1, rdy = 0, go to DMA.
  - Else, data access and i_re both present: issue data access, rdy = 0, go to SPLIT.
  - Else, data access only: issue it, rdy = 1.
  - Else, i_re only: issue fetch, rdy = 1. If x_req is also present, the DMA still waits; the core fetch has priority.
  - Else, core idle and x_req: issue DMA, x_gnt = 1, rdy = 1 (core not stalled), stay in CORE.
- SPLIT:
  - Issue fetch (m_re = 1, m_adr = i_adr), rdy = 1.
  - Capture m_dr (the data read result) into d_hold.
  - Set dsel = 1 for the next cycle, so d_dr = d_hold then. Otherwise d_dr = m_dr.
  - Go to CORE.
- DMA:
  - rdy = 0, no RAM access this cycle.
  - Go to CORE (the core request is re-arbitrated).
- Outputs tied to m_dr:
  - i_dr = m_dr always.
  - x_dr = m_dr.
  - x_vld = 1 in the cycle after a granted DMA read (x_we == 0).
- wcnt:
  - Reset to 0 on x_gnt or !x_req.
  - Otherwise increments each cycle x_req waits, saturating at MAXWAIT.
- m_rdy = 0:
  - All state, counters, d_hold and m_* outputs hold.
  - i_rdy = d_rdy = 0, x_gnt = 0.
  - x_vld and dsel hold.
- Writes:
  - m_re = 0 and m_we = d_we (or x_we); m_dw from the issuing port.
  - Write followed by a read of the same address in the next cycle returns the new data; the RAM handles this, the arbiter does not forward.
- i_rdy and d_rdy are driven from one register/comb term and must never differ.

Test Plan:
- Fetch only:
  - Stimulus: i_re = 1, i_adr = 0x100, no data access, m_dr = 0x00A00093 next cycle.
  - Required: m_adr = 0x100, m_re = 1, rdy = 1; i_dr = 0x00A00093 the following cycle.
- Conflict (split):
  - Stimulus: d_re = 1, d_adr = 0x2000, i_adr = 0x104; RAM returns 0xDEADBEEF then 0x12345678.
  - Required: cycle 1 m_adr = 0x2000, rdy = 0; cycle 2 m_adr = 0x104, rdy = 1; cycle 3 d_dr = 0xDEADBEEF, i_dr = 0x12345678.
- Write conflict:
  - Stimulus: d_we = 4'b0011, d_dw = 0xAAAA5555, d_adr = 0x2004 with fetch.
  - Required: m_we = 0011 in cycle 1, m_re = 1 with fetch in cycle 2, exactly one write issued.
- DMA starvation:
  - Stimulus: core fetches every cycle, x_req = 1, MAXWAIT = 4, x_adr = 0x3000 read.
  - Required: x_gnt on the 5th cycle, rdy = 0 that cycle and the next; x_vld = 1 with x_dr = RAM[0x3000] one cycle after x_gnt; wcnt back to 0.
- Wait state:
  - Stimulus: m_rdy = 0 for 3 cycles during SPLIT.
  - Required: m_adr/m_re frozen, rdy = 0, state stays SPLIT, completes normally after m_rdy = 1.
- Reset mid-operation:
  - Stimulus: reset = 1 in cycle 1 of a split write.
  - Required: next cycle m_we = 0, state CORE, rdy = 0, x_gnt = 0; no further write issued.
